// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4-Lite style word SRAM slave with programmable latency, read bursts and byte strobes
module axi_sram_slave #(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 2,
  parameter int          BURST_LEN = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [29:0] BASE_W = BASE[31:2];
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  logic [31:0] mem [DEPTH];
  r_state_t r_state_q, r_state_d;
  w_state_t w_state_q, w_state_d;
  logic [29:0] r_addr_q, r_addr_d, p_addr, r_next;
  logic [3:0] r_beat_q, r_beat_d, p_beat;
  logic [7:0] r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic [31:0] rdata_q, rdata_d, w_word;
  logic [1:0] rresp_q, rresp_d, bresp_q, bresp_d;
  logic rlast_q, rlast_d, live_q, pres, p_in, w_in, wr_hs;
  logic [AW-1:0] p_idx, w_idx, r_idx;
  logic unused;
  function automatic logic in_range(input logic [29:0] a);
    return {2'b0, a} >= {2'b0, BASE_W} && {2'b0, a} < {2'b0, BASE_W} + 32'(DEPTH);
  endfunction
  assign unused  = ^{araddr[1:0], awaddr[1:0]};
  // live_q holds every ready low for the cycle right after reset
  assign arready = r_state_q == R_IDLE && live_q;
  assign awready = w_state_q == W_IDLE && live_q;
  assign wready  = awready;
  assign rvalid  = r_state_q == R_DATA;
  assign bvalid  = w_state_q == W_RESP;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign bresp   = bresp_q;
  assign wr_hs   = awvalid && wvalid && awready;
  assign r_idx   = AW'(r_addr_q - BASE_W);
  assign r_next  = in_range(r_addr_q) ? BASE_W + 30'(r_idx == AW'(DEPTH - 1) ? '0 : r_idx + 1'b1) : r_addr_q + 30'd1;
  // read engine: accept address, wait out the latency, then stream beats
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d = r_addr_q;
    r_beat_d = r_beat_q;
    r_cnt_d = r_cnt_q;
    pres = 1'b0;
    p_addr = r_addr_q;
    p_beat = r_beat_q;
    if (r_state_q == R_IDLE && arvalid && arready) begin
      r_addr_d = araddr[31:2];
      r_beat_d = '0;
      r_cnt_d = 8'(READ_LAT - 1);
      r_state_d = READ_LAT == 1 ? R_DATA : R_WAIT;
      pres = READ_LAT == 1;
      p_addr = araddr[31:2];
      p_beat = '0;
    end else if (r_state_q == R_WAIT) begin
      r_cnt_d = r_cnt_q - 8'd1;
      r_state_d = r_cnt_q == 8'd1 ? R_DATA : R_WAIT;
      pres = r_cnt_q == 8'd1;
    end else if (r_state_q == R_DATA && rready) begin
      r_state_d = rlast_q ? R_IDLE : R_DATA;
      r_addr_d = rlast_q ? r_addr_q : r_next;
      r_beat_d = rlast_q ? r_beat_q : r_beat_q + 4'd1;
      pres = !rlast_q;
      p_addr = r_next;
      p_beat = r_beat_q + 4'd1;
    end
  end
  // beat capture; a write accepted on the same edge is forwarded so the beat sees new data
  always_comb begin
    p_in = in_range(p_addr);
    p_idx = AW'(p_addr - BASE_W);
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    if (pres) begin
      rdata_d = !p_in ? '0 : (wr_hs && w_in && w_idx == p_idx) ? w_word : mem[p_idx];
      rresp_d = p_in ? 2'b00 : 2'b10;
      rlast_d = p_beat == 4'(BURST_LEN - 1);
    end
  end
  // write engine: joint AW/W accept, strobe merge, delayed response
  always_comb begin
    w_in = in_range(awaddr[31:2]);
    w_idx = AW'(awaddr[31:2] - BASE_W);
    w_word = mem[w_idx];
    for (int i = 0; i < 4; i++) w_word[8*i+:8] = wstrb[i] ? wdata[8*i+:8] : w_word[8*i+:8];
    w_state_d = w_state_q;
    w_cnt_d = w_cnt_q;
    bresp_d = bresp_q;
    if (w_state_q == W_IDLE && wr_hs) begin
      bresp_d = w_in ? 2'b00 : 2'b10;
      w_cnt_d = 8'(WRITE_LAT - 1);
      w_state_d = WRITE_LAT == 1 ? W_RESP : W_WAIT;
    end else if (w_state_q == W_WAIT) begin
      w_cnt_d = w_cnt_q - 8'd1;
      w_state_d = w_cnt_q == 8'd1 ? W_RESP : W_WAIT;
    end else if (w_state_q == W_RESP && bready) begin
      w_state_d = W_IDLE;
    end
  end
  // state registers; reset abandons both engines
  always_ff @(posedge clk) begin
    live_q <= !rst;
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      r_addr_q <= '0;
      r_beat_q <= '0;
      r_cnt_q <= '0;
      w_cnt_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      bresp_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      r_addr_q <= r_addr_d;
      r_beat_q <= r_beat_d;
      r_cnt_q <= r_cnt_d;
      w_cnt_q <= w_cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
      bresp_q <= bresp_d;
    end
  end
  // array update on the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_hs && w_in) mem[w_idx] <= w_word;
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized self-checking bench against a word-array reference model
module tb_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 64, RL = 3, WL = 2, BL = 4;
  logic clk = 0, rst = 1;
  logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [31:0] araddr = 0, awaddr = 0, wdata = 0;
  logic [3:0] wstrb = 0;
  logic arready, rvalid, rlast, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  int checks = 0, errors = 0;
  logic [31:0] mdl [DEPTH];

  always #5 clk = ~clk;

  axi_sram_slave #(.BASE(BASE), .DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL), .BURST_LEN(BL), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .awvalid(awvalid), .awaddr(awaddr),
    .awready(awready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready), .bvalid(bvalid),
    .bready(bready), .bresp(bresp));

  function automatic logic [31:0] wa(input int i);
    return BASE + 32'(4 * i);
  endfunction
  function automatic logic in_rng(input logic [31:0] a);
    longint unsigned x;
    x = a;
    return x >= longint'(BASE) && x < longint'(BASE) + 4 * DEPTH;
  endfunction
  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  // expected data/resp of beat b of a burst starting at byte address a
  function automatic void beat_exp(input logic [31:0] a, input int b, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] c;
    c = {a[31:2], 2'b00};
    for (int i = 0; i < b; i++) c = in_rng(c) ? wa((idx(c) + 1) % DEPTH) : c + 32'd4;
    d = in_rng(c) ? mdl[idx(c)] : 32'd0;
    r = in_rng(c) ? 2'b00 : 2'b10;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    logic [1:0] er;
    int k;
    er = in_rng(a) ? 2'b00 : 2'b10;
    @(negedge clk);
    awvalid = 1; awaddr = a; wdata = d; wstrb = s; wvalid = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
        errors++; $display("FAIL aw_only_hold cyc=%0d got bvalid=%b awready=%b exp bvalid=0 awready=1", i, bvalid, awready);
      end
    end
    wvalid = 1;
    k = 0;
    while (!(awready && wready) && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    if (in_rng(a)) for (int i = 0; i < 4; i++) if (s[i]) mdl[idx(a)][8*i+:8] = d[8*i+:8];
    k = 1;
    @(negedge clk);
    while (!bvalid && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (k !== WL || bvalid !== 1'b1 || bresp !== er) begin
      errors++; $display("FAIL write_resp a=%h got lat=%0d bvalid=%b bresp=%b exp lat=%0d bresp=%b", a, k, bvalid, bresp, WL, er);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++; $display("FAIL write_end got bvalid=%b awready=%b exp 0 1", bvalid, awready);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input int stall_beat, input int stall_n);
    logic [31:0] ed;
    logic [1:0] er;
    int k;
    @(negedge clk);
    arvalid = 1; araddr = a;
    k = 0;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    arvalid = 0;
    k = 1;
    @(negedge clk);
    while (!rvalid && k < 30) begin @(negedge clk); k++; end
    checks++;
    if (k !== RL) begin errors++; $display("FAIL read_latency a=%h got %0d exp %0d", a, k, RL); end
    for (int b = 0; b < BL; b++) begin
      beat_exp(a, b, ed, er);
      checks++;
      if (rvalid !== 1'b1 || rdata !== ed || rresp !== er || rlast !== 1'(b == BL - 1)) begin
        errors++;
        $display("FAIL read_beat%0d a=%h got v=%b d=%h r=%b l=%b exp v=1 d=%h r=%b l=%b", b, a, rvalid, rdata, rresp, rlast, ed, er, b == BL - 1);
      end
      for (int s = 0; s < (b == stall_beat ? stall_n : 0); s++) begin
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== ed || rresp !== er || rlast !== 1'(b == BL - 1)) begin
          errors++; $display("FAIL read_stall_beat%0d got v=%b d=%h r=%b exp v=1 d=%h r=%b", b, rvalid, rdata, rresp, ed, er);
        end
      end
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      @(negedge clk);
    end
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++; $display("FAIL read_end a=%h got rvalid=%b arready=%b exp 0 1", a, rvalid, arready);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp} !== '0) begin
      errors++; $display("FAIL reset_outputs got ar=%b rv=%b rd=%h aw=%b bv=%b exp all 0", arready, rvalid, rdata, awready, bvalid);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (arready !== 1'b0 || awready !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL reset_first_cycle got ar=%b aw=%b w=%b exp 0 0 0", arready, awready, wready);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got ar=%b aw=%b w=%b exp 1 1 1", arready, awready, wready);
    end
  endtask

  task automatic test_preload;
    for (int i = 0; i < DEPTH; i++) axi_write(wa(i), $urandom, 4'hf, 0);
  endtask

  task automatic test_single_read;
    axi_write(BASE, 32'hDEAD_BEEF, 4'hf, 0);
    axi_read(BASE, -1, 0);
  endtask

  task automatic test_burst_backpressure;
    for (int i = 0; i < 4; i++) axi_write(wa(i), 32'(i + 1), 4'hf, 0);
    axi_read(BASE, 1, 3);
    axi_read(wa(DEPTH - 2), 2, 2);
  endtask

  task automatic test_strobe;
    axi_write(wa(5), 32'h1122_3344, 4'hf, 0);
    axi_write(wa(5), 32'hAABB_CCDD, 4'b0101, 0);
    checks++;
    if (mdl[5] !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_model got %h exp 11bb33dd", mdl[5]); end
    axi_read(wa(5), 0, 1);
    axi_write(wa(6), 32'hFFFF_FFFF, 4'b0000, 0);
    axi_read(wa(6), -1, 0);
  endtask

  task automatic test_error;
    axi_read(32'h0000_0000, 2, 1);
    axi_write(wa(DEPTH), 32'hCAFE_F00D, 4'hf, 0);
    axi_read(wa(DEPTH - 4), -1, 0);
  endtask

  task automatic test_concurrency;
    fork
      axi_read(wa(20), 1, 2);
      axi_write(wa(40), $urandom, 4'hf, 5);
    join
    axi_read(wa(40), -1, 0);
    fork
      axi_read(wa(29), -1, 0);
      axi_write(wa(30), $urandom, 4'hf, 0);
    join
  endtask

  task automatic test_collision;
    logic [31:0] old, nw, ed;
    logic [1:0] er;
    int k;
    old = mdl[10];
    nw = ~old;
    @(negedge clk);
    arvalid = 1; araddr = wa(10);
    @(posedge clk); #1;
    arvalid = 0;
    k = 0;
    @(negedge clk);
    while (!rvalid && k < 30) begin @(negedge clk); k++; end
    awvalid = 1; wvalid = 1; awaddr = wa(10); wdata = nw; wstrb = 4'hf; bready = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    mdl[10] = nw;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== old) begin
        errors++; $display("FAIL collision_held got v=%b d=%h exp v=1 d=%h", rvalid, rdata, old);
      end
    end
    bready = 0;
    for (int b = 1; b <= BL; b++) begin
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      @(negedge clk);
      if (b < BL) begin
        beat_exp(wa(10), b, ed, er);
        checks++;
        if (rvalid !== 1'b1 || rdata !== ed) begin
          errors++; $display("FAIL collision_beat%0d got v=%b d=%h exp v=1 d=%h", b, rvalid, rdata, ed);
        end
      end
    end
    checks++;
    if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
      errors++; $display("FAIL collision_end got rvalid=%b bvalid=%b exp 0 0", rvalid, bvalid);
    end
    axi_read(wa(10), -1, 0);
  endtask

  task automatic test_reset_mid_burst;
    int k;
    @(negedge clk);
    arvalid = 1; araddr = BASE;
    awvalid = 1; wvalid = 1; awaddr = BASE; wstrb = 4'h0;
    @(posedge clk); #1;
    arvalid = 0; awvalid = 0; wvalid = 0;
    k = 0;
    @(negedge clk);
    while (!rvalid && k < 30) begin @(negedge clk); k++; end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== mdl[1] || bvalid !== 1'b1) begin
      errors++; $display("FAIL mid_burst_beat2 got v=%b d=%h bv=%b exp v=1 d=%h bv=1", rvalid, rdata, bvalid, mdl[1]);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got ar=%b rv=%b rd=%h bv=%b exp all 0", arready, rvalid, rdata, bvalid);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ready got ar=%b rv=%b exp 1 0", arready, rvalid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_abandon got bv=%b rv=%b exp 0 0", bvalid, rvalid);
    end
    axi_read(BASE, 3, 1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int wi, ri;
      wi = $urandom_range(0, DEPTH - 1);
      ri = $urandom_range(0, DEPTH - 1);
      case ($urandom_range(0, 2))
        0: axi_write(wa(wi), $urandom, 4'($urandom), $urandom_range(0, 2));
        1: axi_read(wa(ri), $urandom_range(0, BL - 1), $urandom_range(0, 3));
        default: fork
          axi_read(wa(ri), $urandom_range(0, BL - 1), $urandom_range(0, 3));
          axi_write(wa(wi), $urandom, 4'($urandom), $urandom_range(0, 3));
        join
      endcase
    end
  endtask

  initial begin
    test_reset;
    test_preload;
    test_single_read;
    test_burst_backpressure;
    test_strobe;
    test_error;
    test_concurrency;
    test_collision;
    test_reset_mid_burst;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
